ovl_next_window: RTL and testbench
==================================

Name: ovl_next_window

Overview:
- Parametrised successor to the single-bit "next" checker.
- Monitors NUM_CH independent channels. Each start_event[c] requires test_expr[c] to be high at least once within a window of MIN_CKS..MAX_CKS cycles after the start.
- Each channel tracks up to MAX_CKS overlapping outstanding starts, adds X/Z checking, and keeps saturating coverage counters.
- Synthesizable RTL: used by the checker library for simulation, emulation and formal alike, not bound to PSL vunits.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- MIN_CKS, 1: earliest start age at which test_expr satisfies a start (>=1).
- MAX_CKS, 4: latest start age at which test_expr satisfies a start (>=MIN_CKS, <=64).
- CHECK_OVERLAPPING, 1: 1 = fire on a start while a prior start is outstanding.
- CHECK_MISSING_START, 1: 1 = fire on test_expr high with no start in window.
- CNT_W, 16: coverage counter width.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: 0 = clear all pending starts and mask all fires.
- xzcheck_enable, in, 1: enables X/Z detection.
- start_event, in, NUM_CH: per-channel start.
- test_expr, in, NUM_CH: per-channel expected event.
- fire_missing_test, out, NUM_CH: a start aged MAX_CKS without being satisfied.
- fire_missing_start, out, NUM_CH: test_expr high with no start in window.
- fire_overlap, out, NUM_CH: start while outstanding.
- fire_xz, out, NUM_CH: start_event or test_expr is X/Z.
- cov_start_count, out, CNT_W: total starts accepted, all channels.
- cov_met_count, out, CNT_W: total starts satisfied, all channels.

Behaviour:
- Reset: all fire outputs 0, both counters 0, all pending bits 0. Reset mid-operation discards outstanding starts with no fire.
- Per-channel state: pend[1..MAX_CKS]. pend[k]=1 means an unsatisfied start occurred k cycles ago.
- win(c) = OR of pend[k] for k in MIN_CKS..MAX_CKS.
- sat(c) = test_expr[c] & win(c). When sat(c), every pend[k] in the window clears; one test_expr pulse satisfies all in-window starts.
- Next state: pend[1] <= start_event[c]; pend[k+1] <= pend[k] & ~(test_expr[c] & k in window). Bits at age MAX_CKS retire.
- All fires are registered, one-cycle pulses appearing the cycle after the evaluating edge:
  - fire_missing_test[c]: pend[MAX_CKS] & ~test_expr[c].
  - fire_missing_start[c]: CHECK_MISSING_START & test_expr[c] & ~win(c).
  - fire_overlap[c]: CHECK_OVERLAPPING & start_event[c] & OR(pend[1..MAX_CKS-1]). The start is still recorded.
- Simultaneous events:
  - A start and a test_expr in the same cycle: the new start (age 0) is not satisfied by that test_expr.
  - A start in the same cycle as the retiring age-MAX_CKS bit is not an overlap.
- enable=0: pend cleared next edge, fires forced 0, counters hold.
- X/Z handling, per channel: if xzcheck_enable and start_event[c] or test_expr[c] is X/Z:
  - fire_xz[c]=1 next cycle;
  - that channel's inputs are treated as 0 for that cycle.
  - Synthesis sees no X; the detection logic is wrapped by the simulation-only guard.
- Counters:
  - cov_start_count += popcount(accepted starts).
  - cov_met_count += number of pend bits cleared by sat (multiple per channel possible).
  - Both saturate at 2^CNT_W-1 and never wrap.
- Parameter violation (MIN_CKS<1, MAX_CKS<MIN_CKS, MAX_CKS>64) triggers the library error task at elaboration, under the 2-state fire type.

Decomposition:
- Shared package ovl_next_pkg holds:
  - fire-class index constants (MISSING_TEST=0, MISSING_START=1, OVERLAP=2, XZ=3);
  - MAX_CKS_LIMIT=64;
  - the saturating-add function.
- Sub-module ovl_next_window_lane: one channel, containing the pend register, fire flops and per-lane start/met counts per cycle.
- The top generates NUM_CH lanes, sums the per-lane increments and owns the saturating counters.

Test Plan:
- NUM_CH=1, MIN=2, MAX=4; start at t0, test_expr at t3 -> no fires; cov_start=1, cov_met=1.
- Same params; start at t0, no test_expr -> fire_missing_test pulses exactly at t5 (evaluated t4, registered) for 1 cycle.
- Starts at t0 and t1, test_expr at t3 -> both satisfied, cov_met=2; fire_overlap pulses at t2 (CHECK_OVERLAPPING=1); with CHECK_OVERLAPPING=0 no overlap fire.
- test_expr at t1 after start at t0 with MIN=2 -> fire_missing_start at t2; then fire_missing_test at t5.
- NUM_CH=4, start on ch2 with test_expr X -> fire_xz=4'b0100 next cycle; with xzcheck_enable=0 no fire.
- CNT_W=4, 20 starts all met -> both counters hold at 15; reset asserted with 3 pending -> no fires afterwards, counters 0.

Source files
------------

// File: rtl/ovl_next_window_pkg.sv
// Shared definitions for the next-window checker: fire-class indices,
// window limit and the saturating adder used by the coverage counters.
package ovl_next_pkg;

  localparam int MISSING_TEST  = 0;
  localparam int MISSING_START = 1;
  localparam int OVERLAP       = 2;
  localparam int XZ            = 3;
  localparam int NUM_FIRE      = 4;

  localparam int MAX_CKS_LIMIT = 64;

  // Clamps a + b to 2^w-1; also catches the 64-bit carry-out when w == 64.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum = a + b;
    if (sum > lim || sum < a) return lim;
    return sum;
  endfunction

endpackage

// File: rtl/ovl_next_window_lane.sv
// One channel of the next-window checker: age-indexed pending starts,
// registered fire pulses and this cycle's start/met increments.
module ovl_next_window_lane
  import ovl_next_pkg::*;
#(
  parameter int MIN_CKS             = 1,
  parameter int MAX_CKS             = 4,
  parameter bit CHECK_OVERLAPPING   = 1'b1,
  parameter bit CHECK_MISSING_START = 1'b1,
  parameter int MET_W               = $clog2(MAX_CKS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                xzcheck_enable,
  input  logic                start_event,
  input  logic                test_expr,
  output logic [NUM_FIRE-1:0] fire,
  output logic                start_inc,
  output logic [MET_W-1:0]    met_inc
);

  function automatic logic [MAX_CKS:1] range_mask(input int lo, input int hi);
    logic [MAX_CKS:1] m;
    m = '0;
    for (int k = 1; k <= MAX_CKS; k++) m[k] = (k >= lo) && (k <= hi);
    return m;
  endfunction

  localparam logic [MAX_CKS:1] WIN_MASK   = range_mask(MIN_CKS, MAX_CKS);
  localparam logic [MAX_CKS:1] YOUNG_MASK = range_mask(1, MAX_CKS - 1);

  logic [MAX_CKS:1] pend, pend_nxt, cleared, kept;
  logic             se, te, xz, win;

  always_comb begin
    se = start_event;
    te = test_expr;
    xz = 1'b0;
`ifndef SYNTHESIS
    if (xzcheck_enable && $isunknown({start_event, test_expr})) begin
      se = 1'b0;
      te = 1'b0;
      xz = 1'b1;
    end
`endif
    win     = |(pend & WIN_MASK);
    cleared = (te && win) ? (pend & WIN_MASK) : '0;
    kept    = pend & ~cleared;
    // Age 0 start enters at age 1 untouched by this cycle's test_expr.
    pend_nxt    = '0;
    pend_nxt[1] = se;
    for (int k = 2; k <= MAX_CKS; k++) pend_nxt[k] = kept[k-1];
  end

  assign start_inc = enable & se;
  assign met_inc   = enable ? MET_W'($countones(cleared)) : '0;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pend <= '0;
      fire <= '0;
    end else begin
      pend                <= pend_nxt;
      fire[MISSING_TEST]  <= pend[MAX_CKS] & ~te;
      fire[MISSING_START] <= CHECK_MISSING_START & te & ~win;
      fire[OVERLAP]       <= CHECK_OVERLAPPING & se & (|(pend & YOUNG_MASK));
      fire[XZ]            <= xz;
    end
  end

endmodule

// File: rtl/ovl_next_window.sv
// Multi-channel next-window checker: NUM_CH independent lanes plus shared
// saturating coverage counters of accepted and satisfied starts.
module ovl_next_window
  import ovl_next_pkg::*;
#(
  parameter int NUM_CH              = 4,
  parameter int MIN_CKS             = 1,
  parameter int MAX_CKS             = 4,
  parameter bit CHECK_OVERLAPPING   = 1'b1,
  parameter bit CHECK_MISSING_START = 1'b1,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              xzcheck_enable,
  input  logic [NUM_CH-1:0] start_event,
  input  logic [NUM_CH-1:0] test_expr,
  output logic [NUM_CH-1:0] fire_missing_test,
  output logic [NUM_CH-1:0] fire_missing_start,
  output logic [NUM_CH-1:0] fire_overlap,
  output logic [NUM_CH-1:0] fire_xz,
  output logic [CNT_W-1:0]  cov_start_count,
  output logic [CNT_W-1:0]  cov_met_count
);

  if (MIN_CKS < 1 || MAX_CKS < MIN_CKS || MAX_CKS > MAX_CKS_LIMIT) begin : g_bad_param
    $error("ovl_next_window: illegal MIN_CKS/MAX_CKS combination");
  end

  localparam int MET_W = $clog2(MAX_CKS + 1);
  localparam int SUM_W = $clog2(NUM_CH * MAX_CKS + 1);

  logic [NUM_CH-1:0][NUM_FIRE-1:0] fire;
  logic [NUM_CH-1:0]               start_inc;
  logic [NUM_CH-1:0][MET_W-1:0]    met_inc;
  logic [SUM_W-1:0]                start_sum, met_sum;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    ovl_next_window_lane #(
      .MIN_CKS            (MIN_CKS),
      .MAX_CKS            (MAX_CKS),
      .CHECK_OVERLAPPING  (CHECK_OVERLAPPING),
      .CHECK_MISSING_START(CHECK_MISSING_START),
      .MET_W              (MET_W)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .xzcheck_enable(xzcheck_enable),
      .start_event   (start_event[c]),
      .test_expr     (test_expr[c]),
      .fire          (fire[c]),
      .start_inc     (start_inc[c]),
      .met_inc       (met_inc[c])
    );
    assign fire_missing_test[c]  = fire[c][MISSING_TEST];
    assign fire_missing_start[c] = fire[c][MISSING_START];
    assign fire_overlap[c]       = fire[c][OVERLAP];
    assign fire_xz[c]            = fire[c][XZ];
  end

  always_comb begin
    start_sum = '0;
    met_sum   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      start_sum = start_sum + SUM_W'(start_inc[c]);
      met_sum   = met_sum + SUM_W'(met_inc[c]);
    end
  end

  // Increments are already zero while disabled, so counters hold then.
  always_ff @(posedge clk) begin
    if (reset) begin
      cov_start_count <= '0;
      cov_met_count   <= '0;
    end else begin
      cov_start_count <= CNT_W'(sat_add(64'(cov_start_count), 64'(start_sum), CNT_W));
      cov_met_count   <= CNT_W'(sat_add(64'(cov_met_count), 64'(met_sum), CNT_W));
    end
  end

endmodule

// File: tb/tb_ovl_next_window.sv
// Directed + random bench for ovl_next_window: a list-of-ages reference model
// pushes expected outputs per cycle; they are popped and checked after the edge.
module tb_ovl_next_window;

  localparam int NCH  = 4;
  localparam int MIN  = 2;
  localparam int MAX  = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic           clk;
  logic           reset, enable, xzcheck_enable;
  logic [NCH-1:0] start_event, test_expr;
  logic [NCH-1:0] a_mt, a_ms, a_ov, a_xz, b_mt, b_ms, b_ov, b_xz;
  logic [CW-1:0]  a_st, a_met, b_st, b_met;

  ovl_next_window #(.NUM_CH(NCH), .MIN_CKS(MIN), .MAX_CKS(MAX), .CHECK_OVERLAPPING(1'b1),
                    .CHECK_MISSING_START(1'b1), .CNT_W(CW)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .xzcheck_enable(xzcheck_enable),
    .start_event(start_event), .test_expr(test_expr),
    .fire_missing_test(a_mt), .fire_missing_start(a_ms), .fire_overlap(a_ov), .fire_xz(a_xz),
    .cov_start_count(a_st), .cov_met_count(a_met));

  ovl_next_window #(.NUM_CH(NCH), .MIN_CKS(MIN), .MAX_CKS(MAX), .CHECK_OVERLAPPING(1'b0),
                    .CHECK_MISSING_START(1'b0), .CNT_W(CW)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .xzcheck_enable(xzcheck_enable),
    .start_event(start_event), .test_expr(test_expr),
    .fire_missing_test(b_mt), .fire_missing_start(b_ms), .fire_overlap(b_ov), .fire_xz(b_xz),
    .cov_start_count(b_st), .cov_met_count(b_met));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int age;
  } pend_t;

  typedef struct packed {
    logic [NCH-1:0] mt, ms, ov, xz;
    logic [CW-1:0]  st, met;
  } exp_t;

  pend_t pq[$];
  exp_t  sb[$];
  int    m_start, m_met;
  int    total, bad;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, act, exp);
    end
  endtask

  // Reference model: outstanding starts kept as (channel, age) records.
  task automatic model_step();
    exp_t           e;
    pend_t          nq[$];
    logic [NCH-1:0] se_e, te_e, win, young, old;
    int             ns, nm;
    e = '0; se_e = '0; te_e = '0; ns = 0; nm = 0;
    if (reset) begin
      pq.delete();
      m_start = 0;
      m_met   = 0;
    end else if (!enable) begin
      pq.delete();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (xzcheck_enable && ($isunknown(start_event[c]) || $isunknown(test_expr[c])))
          e.xz[c] = 1'b1;
        else begin
          se_e[c] = start_event[c];
          te_e[c] = test_expr[c];
        end
      end
      win = '0; young = '0; old = '0;
      foreach (pq[i]) begin
        if (pq[i].age >= MIN && pq[i].age <= MAX) win[pq[i].ch] = 1'b1;
        if (pq[i].age < MAX) young[pq[i].ch] = 1'b1;
        if (pq[i].age == MAX) old[pq[i].ch] = 1'b1;
      end
      e.mt = old & ~te_e;
      e.ms = te_e & ~win;
      e.ov = se_e & young;
      foreach (pq[i]) begin
        if (te_e[pq[i].ch] && pq[i].age >= MIN && pq[i].age <= MAX) nm++;
        else if (pq[i].age < MAX) nq.push_back('{ch: pq[i].ch, age: pq[i].age + 1});
      end
      for (int c = 0; c < NCH; c++)
        if (se_e[c]) begin
          nq.push_back('{ch: c, age: 1});
          ns++;
        end
      pq = nq;
      m_start = (m_start + ns > CMAX) ? CMAX : m_start + ns;
      m_met   = (m_met + nm > CMAX) ? CMAX : m_met + nm;
    end
    e.st  = CW'(m_start);
    e.met = CW'(m_met);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk("a_missing_test", a_mt, e.mt);
    chk("a_missing_start", a_ms, e.ms);
    chk("a_overlap", a_ov, e.ov);
    chk("a_xz", a_xz, e.xz);
    chk("a_cov_start", a_st, e.st);
    chk("a_cov_met", a_met, e.met);
    chk("b_missing_test", b_mt, e.mt);
    chk("b_missing_start", b_ms, 4'b0000);
    chk("b_overlap", b_ov, 4'b0000);
    chk("b_xz", b_xz, e.xz);
    chk("b_cov_start", b_st, e.st);
    chk("b_cov_met", b_met, e.met);
  endtask

  task automatic step(input logic r, input logic en, input logic xe,
                      input logic [NCH-1:0] se, input logic [NCH-1:0] te);
    @(negedge clk);
    reset = r; enable = en; xzcheck_enable = xe;
    start_event = se; test_expr = te;
    model_step();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
  endtask

  initial begin
    logic [NCH-1:0] xv;
    total = 0; bad = 0; m_start = 0; m_met = 0;
    reset = 1'b1; enable = 1'b1; xzcheck_enable = 1'b1;
    start_event = '0; test_expr = '0;

    step(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);

    // start t0, test t3 -> satisfied
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0001);
    idle(2);

    // unsatisfied start -> missing_test
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000);
    idle(6);

    // two overlapping starts, one test satisfies both
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0001);
    idle(4);

    // test too early -> missing_start, then missing_test
    step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0001);
    idle(6);

    // same-cycle start and test, and start on the retiring edge
    step(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010);
    idle(3);
    step(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000);
    idle(5);

    // X/Z on channel 2, with and without checking
    xv = 4'b0x00;
    step(1'b0, 1'b1, 1'b1, 4'b0100, xv);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 4'b0100, xv);
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    idle(2);

    // enable low discards pending starts
    step(1'b0, 1'b1, 1'b1, 4'b1010, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    idle(6);

    // mixed random traffic on all channels
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(5);

    // counters saturate at 15
    step(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0001);
    idle(5);

    // reset with three pending starts -> nothing afterwards
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
